// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for serial_adder_n; the requester uses master, the adder uses slave.
// Widths follow WIDTH, which must match the adder instance it connects to.
interface serial_adder_n_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output start, sub, a, b, cin,
      input  sum, cout, ovf, busy, done
   );

   modport slave (
      input  start, sub, a, b, cin,
      output sum, cout, ovf, busy, done
   );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial add/subtract, LSB first, one bit per clock; done pulses WIDTH+1 cycles after start is sampled.
// No backpressure: start is only sampled in IDLE/DONE and ignored while busy; results hold until the next completion.
module serial_adder_n #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   serial_adder_n_if.slave bus
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             s_bit;
   logic             c_nxt;

   always_comb begin
      s_bit  = a_q[0] ^ b_q[0] ^ c_q;
      c_nxt  = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
      res_sh = res_q >> 1;
      res_sh[WIDTH-1] = s_bit;

      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = c_nxt;
            res_d = res_sh;
            cnt_d = cnt_q + 1'b1;
            // On the MSB edge c_q is the carry into the MSB, so ovf needs no extra flop.
            if (cnt_q == LAST) begin
               state_d = ST_DONE;
               sum_d   = res_sh;
               cout_d  = c_nxt;
               ovf_d   = c_q ^ c_nxt;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            if (bus.start) begin
               state_d = ST_RUN;
               a_d     = bus.a;
               b_d     = bus.b ^ {WIDTH{bus.sub}};
               c_d     = bus.sub ? 1'b1 : bus.cin;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = (state_q == ST_RUN);
   assign bus.done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: WIDTH=8 and WIDTH=1 instances share stimulus and are
// checked every cycle against an arithmetic timing/result model plus directed literal cases.
module tb_serial_adder_n;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st  = 1'b0;
   logic       sb  = 1'b0;
   logic       ci  = 1'b0;
   logic [7:0] av  = 8'd0;
   logic [7:0] bv  = 8'd0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_adder_n_if #(.WIDTH(8)) bus8 ();
   serial_adder_n_if #(.WIDTH(1)) bus1 ();

   assign bus8.start = st;
   assign bus8.sub   = sb;
   assign bus8.a     = av;
   assign bus8.b     = bv;
   assign bus8.cin   = ci;
   assign bus1.start = st;
   assign bus1.sub   = sb;
   assign bus1.a     = av[0];
   assign bus1.b     = bv[0];
   assign bus1.cin   = ci;

   serial_adder_n #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_adder_n #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Result of a WIDTH-bit add/sub from plain integer arithmetic.
   function automatic void ref_calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic c_in, input logic s_in,
                                    output logic [31:0] r, output logic co, output logic ov);
      logic [63:0] m, bb, full;
      logic        cc;
      m    = (64'd1 << w) - 64'd1;
      bb   = s_in ? (~b & m) : (b & m);
      cc   = s_in ? 1'b1 : c_in;
      full = (a & m) + bb + {63'd0, cc};
      r    = 32'(full & m);
      co   = full[w];
      ov   = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
   endfunction

   // Timing model: an accepted start at edge e completes at edge e+w; starts are
   // ignored while an accepted op has not yet reached its completion edge.
   int          edge_no = 0;
   logic        model_ok = 1'b0;
   logic        pend[2];
   int          done_edge[2];
   logic [31:0] cap_sum[2], exp_sum[2];
   logic        cap_co[2], cap_ov[2], exp_co[2], exp_ov[2], exp_busy[2], exp_done[2];
   int          mw;
   logic        mrun;

   always @(posedge clk) begin
      edge_no++;
      for (int d = 0; d < 2; d++) begin
         mw = (d == 0) ? 8 : 1;
         if (rst) begin
            pend[d]    = 1'b0;
            exp_sum[d] = 32'd0;
            exp_co[d]  = 1'b0;
            exp_ov[d]  = 1'b0;
         end else begin
            mrun = pend[d] && (edge_no <= done_edge[d]);
            if (pend[d] && edge_no == done_edge[d]) begin
               exp_sum[d] = cap_sum[d];
               exp_co[d]  = cap_co[d];
               exp_ov[d]  = cap_ov[d];
            end
            if (!mrun && st) begin
               ref_calc(mw, {56'd0, av}, {56'd0, bv}, ci, sb, cap_sum[d], cap_co[d], cap_ov[d]);
               pend[d]      = 1'b1;
               done_edge[d] = edge_no + mw;
            end
         end
         exp_busy[d] = pend[d] && (edge_no < done_edge[d]);
         exp_done[d] = pend[d] && (edge_no == done_edge[d]);
      end
      if (rst) model_ok = 1'b1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("busy8", 64'(bus8.busy), 64'(exp_busy[0]));
         chk("done8", 64'(bus8.done), 64'(exp_done[0]));
         chk("sum8",  64'(bus8.sum),  64'(exp_sum[0]));
         chk("cout8", 64'(bus8.cout), 64'(exp_co[0]));
         chk("ovf8",  64'(bus8.ovf),  64'(exp_ov[0]));
         chk("busy1", 64'(bus1.busy), 64'(exp_busy[1]));
         chk("done1", 64'(bus1.done), 64'(exp_done[1]));
         chk("sum1",  64'(bus1.sum),  64'(exp_sum[1]));
         chk("cout1", 64'(bus1.cout), 64'(exp_co[1]));
         chk("ovf1",  64'(bus1.ovf),  64'(exp_ov[1]));
      end
   end

   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
      @(posedge clk); #1;
      st = 1'b1; av = a; bv = b; ci = c; sb = s;
      @(posedge clk); #1;
      st = 1'b0;
   endtask

   task automatic wait_done(input int which, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!((which == 0) ? bus8.done : bus1.done) && n < 40);
   endtask

   task automatic chk8(input string nm, input logic [7:0] s, input logic co, input logic ov);
      chk({nm, "_sum"},  64'(bus8.sum),  64'(s));
      chk({nm, "_cout"}, 64'(bus8.cout), 64'(co));
      chk({nm, "_ovf"},  64'(bus8.ovf),  64'(ov));
   endtask

   initial begin
      int n;
      int seen;
      logic [1:0] fa;

      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(bus8.busy), 64'd0);
      chk("rst_done", 64'(bus8.done), 64'd0);
      chk8("rst", 8'h00, 1'b0, 1'b0);

      start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
      wait_done(0, n);
      chk("lat_5a3c", 64'(n), 64'd9);
      chk8("add_5a3c", 8'h96, 1'b0, 1'b1);
      @(negedge clk);
      chk("done_pulse", 64'(bus8.done), 64'd0);

      start_op(8'hFF, 8'h01, 1'b0, 1'b0);
      wait_done(0, n);
      chk8("add_ff01", 8'h00, 1'b1, 1'b0);

      start_op(8'h80, 8'h01, 1'b0, 1'b1);
      wait_done(0, n);
      chk8("sub_8001", 8'h7F, 1'b1, 1'b1);

      // Back-to-back: start is raised during the DONE cycle itself.
      start_op(8'h10, 8'h20, 1'b0, 1'b1);
      wait_done(0, n);
      chk8("sub_1020", 8'hF0, 1'b0, 1'b0);
      st = 1'b1; av = 8'h03; bv = 8'h02; sb = 1'b0; ci = 1'b0;
      @(posedge clk); #1;
      st = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 64'(bus8.busy), 64'd1);
      wait_done(0, n);
      chk("b2b_lat", 64'(n), 64'd8);
      chk8("b2b_add", 8'h05, 1'b0, 1'b0);

      // Reset asserted during the 4th RUN cycle aborts the op.
      start_op(8'h12, 8'h34, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(bus8.busy), 64'd0);
      chk8("abort", 8'h00, 1'b0, 1'b0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus8.done) seen++;
      end
      chk("abort_no_done", 64'(seen), 64'd0);

      // A start pulse during the 3rd RUN cycle must not disturb the op.
      start_op(8'h7F, 8'h01, 1'b0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      st = 1'b1; av = 8'h11; bv = 8'h22; sb = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      wait_done(0, n);
      chk("ign_lat", 64'(n), 64'd6);
      chk8("ign", 8'h80, 1'b0, 1'b1);

      // WIDTH=1: full-adder truth table.
      for (int i = 0; i < 8; i++) begin
         fa = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
         start_op({7'd0, i[2]}, {7'd0, i[1]}, i[0], 1'b0);
         wait_done(1, n);
         chk($sformatf("fa%0d_lat", i), 64'(n), 64'd2);
         chk($sformatf("fa%0d_sum", i), 64'(bus1.sum), 64'(fa[0]));
         chk($sformatf("fa%0d_cout", i), 64'(bus1.cout), 64'(fa[1]));
      end

      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 99) == 0);
         st  = ($urandom_range(0, 2) == 0);
         av  = 8'($urandom);
         bv  = 8'($urandom);
         ci  = 1'($urandom);
         sb  = 1'($urandom);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      st  = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_n.md
SERIAL_ADDER_N -- requirements
Module: serial_adder_n

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 1..32.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-006 sub  input  1  0 means add, 1 means subtract (a - b); captured with start.
REQ-007 a  input  WIDTH  operand A; captured with start.
REQ-008 b  input  WIDTH  operand B; captured with start.
REQ-009 cin  input  1  carry-in for add; ignored when sub=1.
REQ-010 sum  output  WIDTH  registered result; held until the next completion.
REQ-011 cout  output  1  registered carry-out of the MSB.
REQ-012 ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-cycle pulse when sum, cout and ovf update.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE->RUN: on a clk edge with start=1, the block SHALL capture the following.
  - a into the A shift register.
  - b XOR {WIDTH{sub}} into the B shift register.
  - carry FF = sub ? 1 : cin.
  - bit counter = 0.
REQ-017 In RUN, each clk edge SHALL process exactly one bit, LSB first, using the full-adder equations on the current LSBs and the carry FF.
  - s = a0^b0^c.
  - c' = a0&b0 | a0&c | b0&c.
  - A and B shift right by one; s shifts into the MSB of an internal result register.
REQ-018 The block SHALL record the carry into the MSB on the bit-(WIDTH-1) edge for the ovf computation.
REQ-019 RUN->DONE SHALL occur on the WIDTH-th RUN edge. On that edge sum, cout and ovf SHALL load together.
REQ-020 done SHALL be 1 for exactly the one cycle spent in DONE. busy SHALL be 0 in DONE.
REQ-021 Latency: if start is sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH, and busy high in the cycles after edges k..k+WIDTH-1.
REQ-022 DONE->RUN SHALL occur if start=1 in DONE (back-to-back operation, same capture as REQ-016). Otherwise DONE->IDLE.
REQ-023 start=1 while in RUN SHALL be ignored. The captured operands and mode SHALL NOT change mid-operation.
REQ-024 sum, cout and ovf SHALL change only on the completion edge; they SHALL be stable in IDLE, RUN and DONE otherwise.
REQ-025 WIDTH=1 SHALL behave as a single full adder: one RUN cycle, ovf = cin-to-MSB XOR cout.
REQ-026 In subtract mode, cout=1 SHALL mean no borrow (a >= b unsigned).

Reset
REQ-027 rst=1 on a clk edge SHALL force IDLE and clear the following to 0: sum, cout, ovf, busy, done, the carry FF, the counter and the shift registers.
REQ-028 rst SHALL take priority over start and over an in-progress RUN. An aborted operation SHALL produce no done pulse and no output update.

Verification
REQ-029 WIDTH=8, add, a=0x5A, b=0x3C, cin=0 -> after 8 RUN cycles: sum=0x96, cout=0, ovf=1, done pulse 1 cycle.
REQ-030 WIDTH=8, add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Also sub, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-031 WIDTH=8, sub, a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow), ovf=0. Then start held high in DONE with a=0x03, b=0x02, add -> the second op completes WIDTH cycles later with sum=0x05 and no IDLE cycle in between.
REQ-032 WIDTH=1, all 8 combinations of a, b, cin in add mode -> sum/cout match the full-adder truth table; done latency is 1 cycle after the start edge.
REQ-033 WIDTH=8, start an op, assert rst on the 4th RUN cycle -> next cycle: IDLE, busy=0, sum=0, cout=0, ovf=0, and no done pulse follows.
REQ-034 WIDTH=8, pulse start with new operands on the 3rd RUN cycle -> ignored; the result equals the originally captured op; done occurs at the original latency.
